// File: rtl/sram_read_skew.sv
// sram_read_skew: reads a block of SRAM rows and re-skews their lanes diagonally
module sram_read_skew #(
   parameter int ARRAY_SIZE = 8,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                             clk,
   input  logic                             srstn,
   input  logic                             start,
   input  logic [ADDR_WIDTH-1:0]            base_addr,
   input  logic [ADDR_WIDTH-1:0]            row_count,
   output logic [ADDR_WIDTH-1:0]            sram_raddr,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] sram_rdata,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] skew_data,
   output logic [ARRAY_SIZE-1:0]            lane_valid,
   output logic                             busy,
   output logic                             done
);
   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
   state_t state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, rows_q, rows_d, raddr_q, raddr_d;
   logic rv_q;
   // control registers; rv_q marks cycles where sram_rdata holds a requested row
   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rows_q  <= '0;
         raddr_q <= '0;
         rv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rows_q  <= rows_d;
         raddr_q <= raddr_d;
         rv_q    <= state_q == READ;
      end
   end
   // next state; the read address is held at zero outside READ and wraps naturally
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rows_d  = rows_q;
      raddr_d = '0;
      case (state_q)
         IDLE: if (start && row_count != '0) begin
            state_d = READ;
            cnt_d   = '0;
            rows_d  = row_count;
            raddr_d = base_addr;
         end
         READ: if (cnt_q == rows_q - 1'b1) begin
            state_d = DRAIN;
            cnt_d   = '0;
         end else begin
            cnt_d   = cnt_q + 1'b1;
            raddr_d = raddr_q + 1'b1;
         end
         DRAIN: if (cnt_q == ADDR_WIDTH'(ARRAY_SIZE)) begin
            state_d = DONE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   assign sram_raddr = raddr_q;
   assign busy       = state_q != IDLE;
   assign done       = state_q == DONE;
   for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_lane
      logic [DATA_WIDTH-1:0] d_q [j+1];
      logic [j:0]            v_q;
      // lane j: element j sits in the MSB-first slice; invalid beats carry zero data
      always_ff @(posedge clk or negedge srstn) begin
         if (!srstn) begin
            for (int s = 0; s <= j; s++) d_q[s] <= '0;
            v_q <= '0;
         end else begin
            d_q[0] <= rv_q ? sram_rdata[(ARRAY_SIZE-1-j)*DATA_WIDTH +: DATA_WIDTH] : '0;
            v_q[0] <= rv_q;
            for (int s = 1; s <= j; s++) begin
               d_q[s] <= d_q[s-1];
               v_q[s] <= v_q[s-1];
            end
         end
      end
      assign skew_data[j*DATA_WIDTH +: DATA_WIDTH] = d_q[j];
      assign lane_valid[j] = v_q[j];
   end
endmodule

// File: tb/tb_sram_read_skew.sv
// tb_sram_read_skew: directed and random transfers checked against a cycle-timing model
module tb_sram_read_skew;
   localparam int AS = 8, DW = 16, AW = 6;
   logic clk = 1'b0, srstn = 1'b0, start = 1'b0;
   logic [AW-1:0] base_addr = '0, row_count = '0, sram_raddr;
   logic [AS*DW-1:0] sram_rdata, skew_data;
   logic [AS-1:0] lane_valid;
   logic busy, done;
   logic [AS*DW-1:0] mem [64];
   int vectors = 0, miscompares = 0;

   sram_read_skew #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .srstn(srstn), .start(start), .base_addr(base_addr), .row_count(row_count),
      .sram_raddr(sram_raddr), .sram_rdata(sram_rdata), .skew_data(skew_data),
      .lane_valid(lane_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   // one-cycle-latency SRAM
   always @(posedge clk) sram_rdata <= mem[sram_raddr];

   function automatic logic [DW-1:0] elem(input int row, input int j);
      logic [AS*DW-1:0] r;
      r = mem[row];
      return r[(AS-1-j)*DW +: DW];
   endfunction

   task automatic set_elem(input int row, input int j, input logic [DW-1:0] v);
      logic [AS*DW-1:0] r;
      r = mem[row];
      r[(AS-1-j)*DW +: DW] = v;
      mem[row] = r;
   endtask

   task automatic chk(input string tag, input logic [AS*DW-1:0] obs, input logic [AS*DW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, ".raddr"}, sram_raddr, '0);
      chk({tag, ".busy"}, busy, '0);
      chk({tag, ".done"}, done, '0);
      chk({tag, ".valid"}, lane_valid, '0);
      chk({tag, ".data"}, skew_data, '0);
   endtask

   task automatic idle_cycles(input int n, input string tag);
      repeat (n) begin
         @(posedge clk); #1;
         check_idle(tag);
      end
   endtask

   // starts a transfer in the current cycle T and checks cycles T+1..T+N+11;
   // returns still inside cycle T+N+11 (IDLE) so a following start is back-to-back
   task automatic xfer(input logic [AW-1:0] b, input int n, input bit poke, input string tag);
      logic [AW-1:0] ea;
      logic [AS-1:0] ev;
      logic [AS*DW-1:0] ed;
      int k;
      start = 1'b1; base_addr = b; row_count = AW'(n);
      @(posedge clk); #1;
      start = 1'b0; base_addr = AW'($urandom); row_count = AW'($urandom);
      for (int c = 1; c <= n + 11; c++) begin
         ea = (c <= n) ? AW'(int'(b) + c - 1) : '0;
         ev = '0; ed = '0;
         for (int j = 0; j < AS; j++) begin
            k = c - 3 - j;
            if (k >= 0 && k < n) begin
               ev[j] = 1'b1;
               ed[j*DW +: DW] = elem((int'(b) + k) % 64, j);
            end
         end
         chk($sformatf("%s.c%0d.raddr", tag, c), sram_raddr, ea);
         chk($sformatf("%s.c%0d.busy", tag, c), busy, (c <= n + 10) ? 1'b1 : 1'b0);
         chk($sformatf("%s.c%0d.done", tag, c), done, (c == n + 10) ? 1'b1 : 1'b0);
         chk($sformatf("%s.c%0d.valid", tag, c), lane_valid, ev);
         chk($sformatf("%s.c%0d.data", tag, c), skew_data, ed);
         if (poke && c == n + 3) begin
            start = 1'b1; row_count = 6'd5;
         end else start = 1'b0;
         if (c < n + 11) begin @(posedge clk); #1; end
      end
   endtask

   initial begin
      for (int r = 0; r < 64; r++) mem[r] = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check_idle("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) srstn = 1'b1;
      idle_cycles(2, "post_reset");
      // reset during the third READ cycle
      start = 1'b1; base_addr = '0; row_count = 6'd4;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_mid.raddr_before", sram_raddr, 6'd2);
      chk("rst_mid.busy_before", busy, 1'b1);
      srstn = 1'b0; #1;
      check_idle("rst_mid.async");
      @(negedge clk) srstn = 1'b1;
      idle_cycles(14, "rst_mid.after");
      // single row, elements 1..8 MSB first
      for (int j = 0; j < AS; j++) set_elem(5, j, DW'(j + 1));
      xfer(6'd5, 1, 1'b0, "single");
      idle_cycles(2, "gap1");
      // full block
      for (int r = 0; r < 8; r++) for (int j = 0; j < AS; j++) set_elem(r, j, DW'(16 * r + j));
      xfer(6'd0, 8, 1'b0, "full");
      idle_cycles(1, "gap2");
      // address wrap
      xfer(6'd62, 4, 1'b0, "wrap");
      idle_cycles(1, "gap3");
      // start pulsed during DRAIN must be ignored
      xfer(6'd10, 3, 1'b1, "poke");
      idle_cycles(14, "poke.after");
      // zero row count ignored
      start = 1'b1; base_addr = 6'd7; row_count = '0;
      @(posedge clk); #1; start = 1'b0;
      check_idle("zero");
      idle_cycles(12, "zero.after");
      // negative element passes unchanged
      set_elem(30, 2, 16'h8000);
      xfer(6'd30, 1, 1'b0, "neg");
      // back-to-back transfers
      xfer(6'd20, 2, 1'b0, "b2b_a");
      xfer(6'd40, 5, 1'b0, "b2b_b");
      idle_cycles(1, "gap4");
      // random transfers over random contents
      for (int i = 0; i < 6; i++) begin
         for (int r = 0; r < 64; r++) mem[r] = {$urandom, $urandom, $urandom, $urandom};
         xfer(AW'($urandom), (i == 0) ? 63 : int'($urandom_range(1, 20)), 1'(i % 2),
              $sformatf("rnd%0d", i));
         idle_cycles(int'($urandom_range(0, 3)), "rnd_gap");
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
